// File: rtl/ata_pkg.sv
// Shared ATA PIO definitions: FSM state encoding and PIO mode 0 cycle counts in C14M cycles.
// Also used by the ata decode block.
package ata_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ACK     = 3'd4,
    ST_ROMWAIT = 3'd5,
    ST_RECOVER = 3'd6
  } ata_state_t;

  localparam int PIO0_SETUP_CYC   = 1;
  localparam int PIO0_ACTIVE_CYC  = 3;
  localparam int PIO0_HOLD_CYC    = 1;
  localparam int PIO0_RECOVER_CYC = 4;
  localparam int PIO0_ROM_CYC     = 2;
  localparam int PIO0_CNT_W       = 4;
  localparam int IORDY_TMO_W      = 6;

  // Counter preload for a phase of 'cyc' cycles; zero-length phases are skipped elsewhere.
  function automatic int cyc_load(input int cyc);
    return (cyc > 0) ? cyc - 1 : 0;
  endfunction

endpackage

// File: rtl/ata_iordy_sync.sv
// IORDY 2-flop synchronizer plus wait-stretch timeout; only built when ATA_IORDY_EN is defined.
module ata_iordy_sync
  import ata_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic iordy,
  input  logic wait_en,
  output logic stall
);

  logic [1:0]             sync_reg;
  logic [IORDY_TMO_W-1:0] tmo_reg;
  logic                   tmo_done;

  assign tmo_done = (tmo_reg == '1);
  // Stretch only while the device holds IORDY low and the timeout has not expired.
  assign stall    = wait_en && !sync_reg[1] && !tmo_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
      tmo_reg  <= '0;
    end else begin
      sync_reg <= {sync_reg[0], iordy};
      if (!wait_en)
        tmo_reg <= '0;
      else if (!sync_reg[1] && !tmo_done)
        tmo_reg <= tmo_reg + IORDY_TMO_W'(1);
    end
  end

endmodule

// File: rtl/ata_pio_timer.sv
// ATA PIO strobe / DTACK timer on C14M. IORDY stretching is compiled in with `define ATA_IORDY_EN.
// Strobes and DTACK are registered from the current state, gated by the address strobe.
module ata_pio_timer
  import ata_pkg::*;
#(
  parameter int SETUP_CYC   = PIO0_SETUP_CYC,
  parameter int ACTIVE_CYC  = PIO0_ACTIVE_CYC,
  parameter int HOLD_CYC    = PIO0_HOLD_CYC,
  parameter int RECOVER_CYC = PIO0_RECOVER_CYC,
  parameter int ROM_CYC     = PIO0_ROM_CYC,
  parameter int CNT_W       = PIO0_CNT_W
) (
  input  logic C14M,
  input  logic RESET_n,
  input  logic AS_CPU_n,
  input  logic RW_n,
  input  logic IDE_SEL,
  input  logic ROM_SEL,
  input  logic IORDY,
  output logic IDE_IOR_n,
  output logic IDE_IOW_n,
  output logic PIO_DTACK_n,
  output logic PIO_BUSY
);

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(cyc_load(SETUP_CYC));
  localparam logic [CNT_W-1:0] ACTIVE_LD  = CNT_W'(cyc_load(ACTIVE_CYC));
  localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(cyc_load(HOLD_CYC));
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(cyc_load(RECOVER_CYC));
  localparam logic [CNT_W-1:0] ROM_LD     = CNT_W'(cyc_load(ROM_CYC));

  localparam ata_state_t AFTER_ACTIVE = (HOLD_CYC == 0)    ? ST_ACK  : ST_HOLD;
  localparam ata_state_t AFTER_IDE    = (RECOVER_CYC == 0) ? ST_IDLE : ST_RECOVER;

  ata_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rw_reg, rw_next;
  logic             rom_reg, rom_next;
  logic             ior_n_reg, iow_n_reg, dtack_n_reg;

  ata_state_t       start_state;
  logic [CNT_W-1:0] start_cnt;
  logic             start_rw, start_rom, start_req;
  logic             cnt_zero, stall;

  assign cnt_zero  = (cnt_reg == '0);
  assign start_req = !AS_CPU_n && (IDE_SEL || ROM_SEL);

`ifdef ATA_IORDY_EN
  logic iordy_wait;
  assign iordy_wait = (state_reg == ST_ACTIVE) && cnt_zero && !AS_CPU_n;

  ata_iordy_sync u_iordy (
    .clk     (C14M),
    .rst_n   (RESET_n),
    .iordy   (IORDY),
    .wait_en (iordy_wait),
    .stall   (stall)
  );
`else
  logic iordy_unused;
  assign iordy_unused = IORDY;
  assign stall        = 1'b0;
`endif

  // Cycle launch, shared by IDLE and by a request that waited out RECOVER; IDE wins over ROM.
  always_comb begin
    start_state = ST_ROMWAIT;
    start_cnt   = ROM_LD;
    start_rw    = rw_reg;
    start_rom   = 1'b1;
    if (IDE_SEL) begin
      start_rom = 1'b0;
      start_rw  = RW_n;
      if (SETUP_CYC == 0) begin
        start_state = ST_ACTIVE;
        start_cnt   = ACTIVE_LD;
      end else begin
        start_state = ST_SETUP;
        start_cnt   = SETUP_LD;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_zero ? '0 : cnt_reg - CNT_W'(1);
    rw_next    = rw_reg;
    rom_next   = rom_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_req) begin
          state_next = start_state;
          cnt_next   = start_cnt;
          rw_next    = start_rw;
          rom_next   = start_rom;
        end
      end
      ST_SETUP: begin
        if (AS_CPU_n) begin
          state_next = ST_IDLE;
        end else if (cnt_zero) begin
          state_next = ST_ACTIVE;
          cnt_next   = ACTIVE_LD;
        end
      end
      ST_ACTIVE: begin
        if (AS_CPU_n) begin
          state_next = AFTER_IDE;
          cnt_next   = RECOVER_LD;
        end else if (cnt_zero && !stall) begin
          state_next = AFTER_ACTIVE;
          cnt_next   = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (AS_CPU_n) begin
          state_next = AFTER_IDE;
          cnt_next   = RECOVER_LD;
        end else if (cnt_zero) begin
          state_next = ST_ACK;
        end
      end
      ST_ROMWAIT: begin
        if (AS_CPU_n)
          state_next = ST_IDLE;
        else if (cnt_zero)
          state_next = ST_ACK;
      end
      ST_ACK: begin
        if (AS_CPU_n) begin
          state_next = rom_reg ? ST_IDLE : AFTER_IDE;
          cnt_next   = RECOVER_LD;
        end
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          if (start_req) begin
            state_next = start_state;
            cnt_next   = start_cnt;
            rw_next    = start_rw;
            rom_next   = start_rom;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge C14M) begin
    if (!RESET_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      rw_reg      <= 1'b1;
      rom_reg     <= 1'b0;
      ior_n_reg   <= 1'b1;
      iow_n_reg   <= 1'b1;
      dtack_n_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      rw_reg      <= rw_next;
      rom_reg     <= rom_next;
      ior_n_reg   <= !((state_reg == ST_ACTIVE) && !AS_CPU_n && rw_reg);
      iow_n_reg   <= !((state_reg == ST_ACTIVE) && !AS_CPU_n && !rw_reg);
      // ROM has no strobe to wait out, so its DTACK fires on the edge ROMWAIT completes.
      dtack_n_reg <= !(!AS_CPU_n && ((state_reg == ST_ACK) ||
                                     ((state_reg == ST_ROMWAIT) && cnt_zero)));
    end
  end

  assign IDE_IOR_n   = ior_n_reg;
  assign IDE_IOW_n   = iow_n_reg;
  assign PIO_DTACK_n = dtack_n_reg;
  assign PIO_BUSY    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ata_pio_timer.sv
// Directed bench for ata_pio_timer: default-parameter instance plus a SETUP=0/HOLD=0 instance.
// Edge e is the e-th rising edge after the address strobe is first sampled low.
module tb_ata_pio_timer;

  logic C14M = 1'b0;
  logic RESET_n = 1'b0;
  logic AS_CPU_n = 1'b1;
  logic RW_n = 1'b1;
  logic IDE_SEL = 1'b0;
  logic ROM_SEL = 1'b0;
  logic IORDY = 1'b1;

  logic ior_n, iow_n, dtack_n, busy;
  logic w_ior_n, w_iow_n, w_dtack_n, w_busy;

  int checks = 0;
  int failures = 0;
  int ior2 = -1;
  int dt2 = -1;

  always #5 C14M = ~C14M;

  ata_pio_timer dut (
    .C14M(C14M), .RESET_n(RESET_n), .AS_CPU_n(AS_CPU_n), .RW_n(RW_n),
    .IDE_SEL(IDE_SEL), .ROM_SEL(ROM_SEL), .IORDY(IORDY),
    .IDE_IOR_n(ior_n), .IDE_IOW_n(iow_n), .PIO_DTACK_n(dtack_n), .PIO_BUSY(busy)
  );

  ata_pio_timer #(.SETUP_CYC(0), .HOLD_CYC(0)) dut_w (
    .C14M(C14M), .RESET_n(RESET_n), .AS_CPU_n(AS_CPU_n), .RW_n(RW_n),
    .IDE_SEL(IDE_SEL), .ROM_SEL(ROM_SEL), .IORDY(IORDY),
    .IDE_IOR_n(w_ior_n), .IDE_IOW_n(w_iow_n), .PIO_DTACK_n(w_dtack_n), .PIO_BUSY(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge C14M);
    #1;
  endtask

  task automatic idle_gap(input int n);
    AS_CPU_n = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) tick();
    check("rst_ior", ior_n, 1);
    check("rst_iow", iow_n, 1);
    check("rst_dtack", dtack_n, 1);
    check("rst_busy", busy, 0);
    RESET_n = 1'b1;
    tick();
    $display("txn reset_init");

    // IDE read, defaults, AS held low through edge 9
    IDE_SEL = 1'b1; RW_n = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      AS_CPU_n = (e < 10) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("rd_ior_e%0d", e), ior_n, (e >= 2 && e <= 4) ? 0 : 1);
      check($sformatf("rd_iow_e%0d", e), iow_n, 1);
      check($sformatf("rd_dtack_e%0d", e), dtack_n, (e >= 6 && e <= 9) ? 0 : 1);
      check($sformatf("rd_busy_e%0d", e), busy, (e < 14) ? 1 : 0);
    end
    idle_gap(4);
    $display("txn ide_read_default");

    // IDE write on SETUP=0/HOLD=0 instance, AS held low through edge 7
    RW_n = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      AS_CPU_n = (e < 8) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("wr_iow_e%0d", e), w_iow_n, (e >= 1 && e <= 3) ? 0 : 1);
      check($sformatf("wr_ior_e%0d", e), w_ior_n, 1);
      check($sformatf("wr_dtack_e%0d", e), w_dtack_n, (e >= 4 && e <= 7) ? 0 : 1);
    end
    idle_gap(8);
    RW_n = 1'b1;
    $display("txn ide_write_fast");

    // Reset in ACTIVE of a read
    for (int e = 0; e <= 7; e++) begin
      RESET_n  = (e >= 3 && e <= 5) ? 1'b0 : 1'b1;
      AS_CPU_n = (e <= 5) ? 1'b0 : 1'b1;
      tick();
      if (e == 2) check("rstmid_ior_pre", ior_n, 0);
      if (e >= 3) begin
        check($sformatf("rstmid_ior_e%0d", e), ior_n, 1);
        check($sformatf("rstmid_dtack_e%0d", e), dtack_n, 1);
        check($sformatf("rstmid_busy_e%0d", e), busy, 0);
      end
    end
    RESET_n = 1'b1;
    idle_gap(4);
    $display("txn reset_mid_active");

    // Back-to-back reads: first released at edge 7, second requested from edge 8
    for (int e = 0; e <= 40; e++) begin
      AS_CPU_n = (e == 7 || dt2 >= 0) ? 1'b1 : 1'b0;
      tick();
      if (e == 6) check("b2b_dtack1_low", dtack_n, 0);
      if (e == 7) check("b2b_dtack1_rel", dtack_n, 1);
      if (e >= 8 && ior_n == 1'b0 && ior2 < 0) ior2 = e;
      if (e >= 8 && dtack_n == 1'b0 && dt2 < 0) dt2 = e;
    end
    check("b2b_ior2_gap", (ior2 >= 11) ? 1 : 0, 1);
    check("b2b_served", (dt2 >= 0) ? 1 : 0, 1);
    check("b2b_end_busy", busy, 0);
    $display("txn ide_read_back_to_back ior2_edge=%0d dtack2_edge=%0d", ior2, dt2);

    // ROM read, AS held low through edge 3
    IDE_SEL = 1'b0; ROM_SEL = 1'b1;
    for (int e = 0; e <= 5; e++) begin
      AS_CPU_n = (e < 4) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("rom_dtack_e%0d", e), dtack_n, (e == 2 || e == 3) ? 0 : 1);
      check($sformatf("rom_ior_e%0d", e), ior_n, 1);
      check($sformatf("rom_iow_e%0d", e), iow_n, 1);
      check($sformatf("rom_busy_e%0d", e), busy, (e < 4) ? 1 : 0);
    end
    ROM_SEL = 1'b0; IDE_SEL = 1'b1;
    idle_gap(2);
    $display("txn rom_read");

    // Abort mid-ACTIVE: AS sampled high at edge 3
    for (int e = 0; e <= 8; e++) begin
      AS_CPU_n = (e < 3) ? 1'b0 : 1'b1;
      tick();
      check($sformatf("abt_ior_e%0d", e), ior_n, (e == 2) ? 0 : 1);
      check($sformatf("abt_dtack_e%0d", e), dtack_n, 1);
      check($sformatf("abt_busy_e%0d", e), busy, (e < 7) ? 1 : 0);
    end
    $display("txn ide_read_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ata_pio_timer.md
Name: ata_pio_timer

Overview:
- Cycle-accurate ATA PIO strobe and DTACK generator, clocked from C14M.
- Sits between the IDE/ROM address decode and the CPU DTACK merge.
- Takes the decoded IDE and ROM selects plus the CPU address strobe. Produces correctly timed IDE_IOR_n/IDE_IOW_n and a registered DTACK for IDE and ROM accesses.
- Replaces the combinational fast DTACK for IDE so PIO mode 0 timing holds at either CPU speed.

Parameters:
- SETUP_CYC, 1, C14M cycles from address-valid to strobe assert (t1); 0 allowed.
- ACTIVE_CYC, 3, C14M cycles the strobe is held low (t2); minimum 1.
- HOLD_CYC, 1, C14M cycles after strobe negate before DTACK asserts (t9/data hold); 0 allowed.
- RECOVER_CYC, 4, C14M cycles after cycle end before the next IDE strobe may start (t2i); 0 allowed.
- ROM_CYC, 2, C14M cycles from ROM select to DTACK; minimum 1.
- CNT_W, 4, phase counter width; every *_CYC must be ≤ 2^CNT_W−1.

Ports:
- C14M, input, 1, 14 MHz clock; all state changes on its rising edge.
- RESET_n, input, 1, synchronous active-low reset sampled on C14M rising edge.
- AS_CPU_n, input, 1, CPU address strobe, already synchronous to C14M.
- RW_n, input, 1, 1 = read, 0 = write; sampled at cycle start.
- IDE_SEL, input, 1, decoded IDE register access (configured and in range).
- ROM_SEL, input, 1, decoded IDE boot ROM access.
- IORDY, input, 1, ATA IORDY; used only when ATA_IORDY_EN is defined.
- IDE_IOR_n, output, 1, ATA read strobe, active low, registered.
- IDE_IOW_n, output, 1, ATA write strobe, active low, registered.
- PIO_DTACK_n, output, 1, DTACK contribution, active low, registered; ANDed into the CPU DTACK by the top.
- PIO_BUSY, output, 1, high in any state other than IDLE.

Behaviour:
- Reset: on any edge with RESET_n = 0, go to IDLE; IDE_IOR_n = 1, IDE_IOW_n = 1, PIO_DTACK_n = 1, PIO_BUSY = 0, counter = 0. Applies mid-operation too; no residual strobe.
- States: IDLE, SETUP, ACTIVE, HOLD, ACK, ROMWAIT, RECOVER.
- Cycle start: in IDLE, AS_CPU_n = 0 with IDE_SEL = 1 latches RW_n into rw_q.
  - Next state is SETUP, or ACTIVE if SETUP_CYC = 0.
  - The counter loads the target state's cycle count minus 1.
- ROM start: AS_CPU_n = 0 with ROM_SEL = 1 (and IDE_SEL = 0) goes to ROMWAIT, counter = ROM_CYC−1.
- IDE_SEL has priority if both selects are high.
- SETUP: strobes stay high. When the counter reaches 0, go to ACTIVE.
- ACTIVE: the strobe chosen by rw_q is low for exactly ACTIVE_CYC cycles (IOR if read, IOW if write). At counter 0, go to HOLD, or ACK if HOLD_CYC = 0. The strobe deasserts on that transition.
- HOLD: strobes high. At counter 0, go to ACK.
- ROMWAIT: at counter 0, go to ACK.
- ACK: PIO_DTACK_n = 0 and held while AS_CPU_n = 0. When AS_CPU_n is sampled 1, PIO_DTACK_n returns to 1 on the same edge.
  - After an IDE cycle: go to RECOVER (counter = RECOVER_CYC−1), or IDLE if RECOVER_CYC = 0.
  - After a ROM cycle: go to IDLE.
- RECOVER: strobes and DTACK high. At counter 0, go to IDLE. An AS_CPU_n=0 with IDE_SEL=1 seen during RECOVER is not dropped: the FSM leaves RECOVER and starts it on the edge after the counter reaches 0. ROM accesses wait the same way.
- Abort: AS_CPU_n sampled 1 in SETUP, ACTIVE, HOLD or ROMWAIT:
  - strobes negate on that edge; DTACK is never asserted;
  - an IDE abort goes to RECOVER if ACTIVE had been entered, otherwise to IDLE;
  - a ROM abort goes to IDLE.
- Latency, default parameters, read (AS sampled low at edge 0):
  - IOR low edges 2–4;
  - DTACK low from edge 6;
  - RECOVER occupies 4 edges after AS negates.
- The counter decrements saturating at 0 and never wraps.
- Outputs change only on clock edges; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro ATA_IORDY_EN.
- Defined:
  - IORDY passes through a 2-flop synchronizer.
  - In ACTIVE, when the counter is 0 and synced IORDY = 0, the state holds and the strobe stays low.
  - A 6-bit timeout counter forces exit after 63 extra cycles; the cycle then completes normally with DTACK (no bus error).
- Not defined: IORDY is ignored, no synchronizer or timeout logic is instantiated, and timing is parameters only.

Decomposition:
- Package ata_pkg: state enum encoding (3-bit localparams ST_IDLE … ST_RECOVER) and default PIO mode 0 cycle constants, shared with the ata decode block.
- One sub-module, ata_iordy_sync (2-flop synchronizer plus timeout counter), instantiated only under ATA_IORDY_EN.

Test Plan:
- Reset held low for 3 cycles during ACTIVE of a read → IOR_n = 1, DTACK_n = 1, BUSY = 0 at the first reset edge; IDLE afterwards.
- IDE read with defaults: AS low at edge 0, held until edge 10 → IOR_n low at edges 2–4 only, DTACK_n low edges 6–9, high at edge 10, BUSY low at edge 14; IOW_n never low.
- IDE write with SETUP_CYC = 0 and HOLD_CYC = 0 → IOW_n low at edges 1–3, DTACK_n low from edge 4; IOR_n stays 1.
- Back-to-back IDE reads, second AS low 1 cycle after the first ends → second IOR_n assertion no earlier than 4 cycles after the first DTACK release; no request dropped.
- ROM read with ROM_CYC = 2 → DTACK_n low at edge 2, no IOR/IOW activity, no RECOVER.
- AS negated at edge 3 mid-ACTIVE → IOR_n high at edge 3, DTACK never asserted, RECOVER 4 cycles. With ATA_IORDY_EN: IORDY low 10 cycles stretches IOR_n to 13 cycles; IORDY stuck low → exit after 63 extra cycles, DTACK asserted.
